// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and sizes for the 4x1 mux scan controller.
//   state_t : scan FSM state encoding (also exported on the debug port)
//   N_CH    : number of mux channels scanned
//   SEL_W   : width of the mux select
//   CNT_W   : width of the dwell counter (covers DWELL up to 15)
package mux_scan_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: scan request and mux-side signals of mux_scan_ctrl.
//   start    : scan request (environment -> controller)
//   y        : selected bit returned by the 4x1 mux (environment -> controller)
//   sel      : mux select (controller -> mux)
//   sample_q : captured channel values, bit i = y while sel==i
//   busy     : scan in progress (SETTLE/SAMPLE)
//   done     : one-cycle pulse when a scan completes
// Handshake: start is a request that is accepted only on an edge where the
// controller is idle (busy==0 and done==0); a request seen while busy or in
// the done cycle is dropped, never queued. done marks the single cycle in
// which the final sample_q is first valid.
interface mux_scan_ctrl_if;
  logic                               start;
  logic                               y;
  logic [mux_scan_pkg::SEL_W-1:0]     sel;
  logic [mux_scan_pkg::N_CH-1:0]      sample_q;
  logic                               busy;
  logic                               done;

  modport master (
    input  start, y,
    output sel, sample_q, busy, done
  );

  modport slave (
    output start, y,
    input  sel, sample_q, busy, done
  );
endinterface

// File: rtl/dwell_timer.sv
// dwell_timer: settle-cycle counter for one mux channel.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count back to zero
//   en       : count this cycle
//   expired  : high in the last of DWELL enabled cycles
// The count starts at 0 in the first settle cycle, so the terminal value is
// DWELL-1 and a DWELL of 1 expires in the very first enabled cycle.
module dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4x1 mux through channels 0..3, waits DWELL settle
// cycles per channel, then captures the mux output into sample_q[sel].
//   clk, rst  : clock, synchronous active-high reset
//   bus       : mux_scan_ctrl_if.master (start, y, sel, sample_q, busy, done)
//   state_dbg : current FSM state
// Parameter DWELL (1..15): settle cycles per channel before sampling.
// Optional macro MUX_SCAN_CONTINUOUS_EN: start held in the done cycle chains
// straight into the next scan; without it the FSM always returns to IDLE.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  mux_scan_ctrl_if.master  bus,
  output state_t           state_dbg
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t            state;
  state_t            state_nx;
  logic [SEL_W-1:0]  sel;
  logic [N_CH-1:0]   sample_q;
  logic              expired;

  // Counter runs only while settling and is held at zero everywhere else,
  // so every channel starts its dwell from a cleared count.
  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != SETTLE),
    .en      (state == SETTLE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (bus.start) state_nx = SETTLE;
      SETTLE: if (expired) state_nx = SAMPLE;
      SAMPLE: state_nx = (sel == LAST_CH) ? DONE : SETTLE;
      DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        state_nx = bus.start ? SETTLE : IDLE;
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // sel advances only on the SAMPLE exit edge; the 2-bit wrap from 3 to 0
  // is what returns sel to channel 0 for the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= '0;
      sample_q <= '0;
    end else if (state == SAMPLE) begin
      sample_q[sel] <= bus.y;
      sel           <= sel + 1'b1;
    end else if (state == IDLE && bus.start) begin
      sel <= '0;
    end
  end

  assign bus.sel      = sel;
  assign bus.sample_q = sample_q;
  assign bus.busy     = (state == SETTLE) || (state == SAMPLE);
  assign bus.done     = (state == DONE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

`ifdef MUX_SCAN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  localparam int P0  = 3;   // DWELL=2 instance: cycles per channel
  localparam int P1  = 2;   // DWELL=1 instance
  localparam int P15 = 16;  // DWELL=15 instance

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs and mux models ----------------
  logic [3:0] d0  = 4'b0000;
  logic [3:0] d1  = 4'b0000;
  logic [3:0] d15 = 4'b0000;

  mux_scan_ctrl_if bus0 ();
  mux_scan_ctrl_if bus1 ();
  mux_scan_ctrl_if bus15 ();

  assign bus0.y  = d0[bus0.sel];
  assign bus1.y  = d1[bus1.sel];
  assign bus15.y = d15[bus15.sel];

  state_t st0, st1, st15;

  mux_scan_ctrl #(.DWELL(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0));
  mux_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));
  mux_scan_ctrl #(.DWELL(15)) u_dut15 (
    .clk(clk), .rst(rst), .bus(bus15), .state_dbg(st15));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the DWELL=2 instance is fully idle.
  task automatic wait_idle0(input string name);
    int n;
    n = 0;
    while ((bus0.busy || bus0.done) && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(bus0.busy || bus0.done), 32'd0);
  endtask

  // ---------------- reference model (DWELL=2 instance) ----------------
  // mt = cycles elapsed since the accepting edge (1..4P are the scan cycles,
  // 4P+1 is the done cycle, 0 is idle). Every P-th scan cycle is a sample.
  int         mt   = 0;
  logic [3:0] msmp = 4'b0000;

  function automatic logic [7:0] model_out();
    int es;
    logic eb, ed;
    eb = (mt >= 1) && (mt <= 4 * P0);
    ed = (mt == 4 * P0 + 1);
    es = eb ? (mt - 1) / P0 : 0;
    return {2'(es), eb, ed, msmp};
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [3:0] d);
    if (r) begin
      mt   = 0;
      msmp = 4'b0000;
    end else begin
      if (mt >= 1 && mt <= 4 * P0 && (mt % P0) == 0)
        msmp[mt / P0 - 1] = d[mt / P0 - 1];
      if (mt == 0)               mt = s ? 1 : 0;
      else if (mt < 4 * P0 + 1)  mt = mt + 1;
      else                       mt = (CONT && s) ? 1 : 0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       start;
    logic [1:0] e_sel;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_smp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int dn;
    int n;
    logic gap_busy, next_busy;

    bus0.start  = 1'b0;
    bus1.start  = 1'b0;
    bus15.start = 1'b0;

    // D=1010, DWELL=2: one full scan, done in the 13th cycle after start.
    // start is also raised mid-scan (rows 5, 9) and must be ignored.
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000};
    tbl[5]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000};
    tbl[7]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0010};
    tbl[8]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0010};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0010};
    tbl[10] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0010};
    tbl[11] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0010};
    tbl[12] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0010};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1010};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1010};

    d0 = 4'b1010;
    for (int i = 0; i < 15; i++) begin
      rst        = tbl[i].rst;
      bus0.start = tbl[i].start;
      tick();
      check($sformatf("table row %0d", i),
            32'({bus0.sel, bus0.busy, bus0.done, bus0.sample_q}),
            32'({tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_smp}));
    end
    bus0.start = 1'b0;

    // ---- start held high across a scan ----
    bus0.start = 1'b1;
    dn = 0;
    gap_busy = 1'b0;
    next_busy = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (bus0.done) dn++;
      if (c == 14) gap_busy = bus0.busy || bus0.done;
      if (c == 15) next_busy = bus0.busy;
    end
    check("held start done count", 32'(dn), CONT ? 32'd2 : 32'd1);
    check("held start cycle 14 active", 32'(gap_busy), CONT ? 32'd1 : 32'd0);
    check("held start cycle 15 busy", 32'(next_busy), 32'd1);
    bus0.start = 1'b0;
    wait_idle0("idle after held start");

    // ---- reset during SETTLE of channel 2 ----
    d0 = 4'b1111;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    n = 0;
    while (bus0.sel != 2'd2 && n < 40) begin
      tick();
      n++;
    end
    check("reached channel 2", 32'(bus0.sel), 32'd2);
    check("channel 2 settling busy", 32'(bus0.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-scan reset outputs",
          32'({bus0.sel, bus0.busy, bus0.done, bus0.sample_q}), 32'd0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus0.done || bus0.busy) dn++;
    end
    check("no activity after reset", 32'(dn), 32'd0);

    // ---- randomized run against the reference model ----
    rst = 1'b1;
    bus0.start = 1'b0;
    tick();
    model_step(1'b1, 1'b0, d0);
    for (int c = 0; c < 400; c++) begin
      check($sformatf("random cycle %0d", c),
            32'({bus0.sel, bus0.busy, bus0.done, bus0.sample_q}), 32'(model_out()));
      rst        = ($urandom_range(0, 49) == 0);
      bus0.start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) d0 = 4'($urandom);
      tick();
      model_step(rst, bus0.start, d0);
    end
    rst = 1'b0;
    bus0.start = 1'b0;

    // ---- DWELL=1: sel sequence 0,0,1,1,2,2,3,3 ----
    d1 = 4'b0110;
    for (int ch = 0; ch < 4; ch++) begin
      exp_q.push_back(32'(ch));
      exp_q.push_back(32'(ch));
    end
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int c = 1; c <= 2 * 4 * P1 / 2; c++) begin
      check($sformatf("dwell1 sel cycle %0d", c), 32'(bus1.sel), exp_q.pop_front());
      tick();
    end
    check("dwell1 done", 32'(bus1.done), 32'd1);
    check("dwell1 sample_q", 32'(bus1.sample_q), 32'b0110);

    // ---- DWELL=15: channel 1 glitches, only the SAMPLE-cycle value counts ----
    d15 = 4'b0101;
    bus15.start = 1'b1;
    tick();
    bus15.start = 1'b0;
    for (int t = 1; t <= 4 * P15; t++) begin
      if (t == 2 * P15 + 1)
        check("dwell15 after ch1 sample", 32'(bus15.sample_q), 32'b0001);
      if (t >= 20 && t < 2 * P15)  d15 = 4'b0111;
      else if (t == 2 * P15)       d15 = 4'b0101;
      else if (t > 2 * P15)        d15 = 4'b0111;
      else                         d15 = 4'b0101;
      if (t > 2 * P15 && t != 3 * P15 && t != 4 * P15) d15[2] = 1'b0;
      else                                              d15[2] = 1'b1;
      tick();
    end
    check("dwell15 done", 32'(bus15.done), 32'd1);
    check("dwell15 sample_q", 32'(bus15.sample_q), 32'b0101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 2, giving the settle cycles per channel before sampling; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a scan request, sampled only in IDLE.
REQ-005 The block SHALL have port y, input, 1 bit: the selected data bit returned by the downstream 4x1 mux.
REQ-006 The block SHALL have port sel, output, 2 bits: drives the Sel input of the 4x1 mux.
REQ-007 The block SHALL have port sample_q, output, 4 bits: captured channel values, bit i is the value of y while sel==i.
REQ-008 The block SHALL have port busy, output, 1 bit: high in SETTLE and SAMPLE.
REQ-009 The block SHALL have port done, output, 1 bit: a single-cycle pulse when a scan completes.

Function
REQ-010 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE; it resets to IDLE.
REQ-011 In IDLE, start==1 SHALL move the FSM to SETTLE at the next edge, with sel=0 and the dwell counter=0.
REQ-012 In SETTLE, the dwell counter SHALL increment each cycle, and the FSM SHALL move to SAMPLE after exactly DWELL cycles in SETTLE.
REQ-013 The SAMPLE state SHALL last one cycle, and sample_q[sel] SHALL load y on the edge that leaves SAMPLE; other sample_q bits are unchanged.
REQ-014 From SAMPLE with sel<3, the FSM SHALL increment sel and return to SETTLE with the counter cleared; with sel==3, it SHALL go to DONE.
REQ-015 sel SHALL change only on the SAMPLE exit edge or on scan start, and it SHALL hold stable throughout SETTLE and SAMPLE.
REQ-016 DONE SHALL last exactly one cycle with done=1; the next state is IDLE (but see REQ-022), and sel returns to 0.
REQ-017 Latency SHALL be: start seen at edge k, then done high during the cycle after edge k+4*(DWELL+1); the final sample_q is valid in that same cycle.
REQ-018 start SHALL be ignored while busy or in DONE; no queuing or restart occurs.
REQ-019 sample_q SHALL hold its value between scans; it is not cleared on start.

Reset
REQ-020 While rst==1 at an edge, the block SHALL set: state=IDLE, sel=0, sample_q=0, busy=0, done=0, dwell counter=0.
REQ-021 rst SHALL take priority over start and over any mid-scan state; a reset during SETTLE or SAMPLE abandons the scan, produces no done pulse, and leaves sample_q=0.

Configuration
REQ-022 Macro MUX_SCAN_CONTINUOUS_EN SHALL control continuous mode:
- Defined: if start==1 in DONE, the next state is SETTLE with sel=0, giving back-to-back scans with done pulsing once per scan.
- Undefined: DONE always goes to IDLE, and start in DONE is ignored.

Structure
REQ-023 Package mux_scan_pkg SHALL hold:
- the state enum type;
- N_CH=4;
- SEL_W=2;
- CNT_W=4.
REQ-024 The dwell counter SHALL be a sub-module dwell_timer with inputs clk, rst, clear, en and output expired; the FSM, sel register and sample_q register stay in mux_scan_ctrl.

Verification
REQ-025 With the mux model y=D[sel], D=4'b1010, DWELL=2, and a 1-cycle start pulse: sample_q=4'b1010, and done is high exactly 13 cycles after the start edge, for one cycle.
REQ-026 With D=4'b0110 and DWELL=1: sel takes values 0,1,2,3, each held for 2 cycles, and the final sample_q=4'b0110.
REQ-027 With start held high for the whole scan (macro undefined): exactly one done pulse occurs, the FSM sits in IDLE for at least one cycle, and a second scan starts only from IDLE.
REQ-028 With rst asserted for one cycle during SETTLE of channel 2: sel=0, sample_q=0, busy=0 after the edge, and no done pulse occurs.
REQ-029 With MUX_SCAN_CONTINUOUS_EN defined, start held high and DWELL=2: done pulses every 13 cycles, and sample_q follows changes of D between scans.
REQ-030 With DWELL=15 and D changed mid-SETTLE of channel 1: the value captured for channel 1 is the value present in the SAMPLE cycle only.
